// File: rtl/network_sequencer_if.sv
// Handshake and status bundle between the network sequencer and its controller/consumer.
interface network_sequencer_if #(
  parameter int unsigned CYC_W = 24
);
  logic             run;
  logic             abort;
  logic             stage_valid;
  logic             out_ack;
  logic [3:0]       cs;
  logic             stage_load;
  logic             stage_start;
  logic             buf_load;
  logic             valid;
  logic             busy;
  logic             err;
  logic [15:0]      frame_cnt;
  logic [CYC_W-1:0] cycle_cnt;

  modport master (
    output run, abort, stage_valid, out_ack,
    input  cs, stage_load, stage_start, buf_load, valid, busy, err,
           frame_cnt, cycle_cnt
  );

  modport slave (
    input  run, abort, stage_valid, out_ack,
    output cs, stage_load, stage_start, buf_load, valid, busy, err,
           frame_cnt, cycle_cnt
  );
endinterface

// File: rtl/network_sequencer.sv
// Schedule controller for the cube-classification network: walks the shared
// datapath through buffering, four conv passes, affine, ELU and compare, then
// holds the result until acknowledged.
// Optional feature: define NETWORK_SEQ_TIMEOUT_EN to add a per-stage watchdog.
module network_sequencer #(
  parameter int unsigned BUF_CYCLES = 1,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned CYC_W      = 24
) (
  input logic               clk,
  input logic               rst,
  network_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    LIDLE  = 4'd0,
    BUFFER = 4'd1,
    LAYER0 = 4'd2,
    LAYER1 = 4'd3,
    LAYER2 = 4'd4,
    LAYER3 = 4'd5,
    AFFINE = 4'd6,
    ELU    = 4'd7,
    COMP   = 4'd8,
    LFIN   = 4'd9
  } state_t;

  // Reject out-of-range parameters at elaboration
  if (BUF_CYCLES < 1 || BUF_CYCLES > 255 || TIMEOUT < 2 || CYC_W < 1) begin : g_bad_param
    $error("network_sequencer: parameter out of range");
  end

  state_t           state, state_nx;
  logic             accept_run, frame_done;
  logic             stage_start_nx, qual_valid, counting;
  logic [7:0]       buf_cnt;
  logic             stage_start_q, stage_load_q, buf_load_q, valid_q, busy_q;
  logic [15:0]      frame_cnt_q;
  logic [CYC_W-1:0] cycle_cnt_q;

  function automatic logic is_compute(input state_t s);
    return (s >= LAYER0) && (s <= COMP);
  endfunction

  // A valid on the entry cycle is stale from the previous pass and is masked
  assign qual_valid     = bus.stage_valid && !stage_start_q;
  assign stage_start_nx = is_compute(state_nx) && (state_nx != state);
  assign counting       = (state >= BUFFER) && (state <= COMP);

`ifdef NETWORK_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit, wd_expire, err_q;

  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

  // Per-stage watchdog, restarted on every compute-state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 wd_cnt <= '0;
    else if (stage_start_nx) wd_cnt <= '0;
    else if (stage_load_q)   wd_cnt <= wd_cnt + WD_W'(1);
  end

  // Sticky error, cleared when a new frame is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             err_q <= 1'b0;
    else if (accept_run) err_q <= 1'b0;
    else if (wd_expire)  err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LIDLE;
    else     state <= state_nx;
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_nx   = state;
    accept_run = 1'b0;
    frame_done = 1'b0;
`ifdef NETWORK_SEQ_TIMEOUT_EN
    wd_expire  = 1'b0;
`endif
    case (state)
      LIDLE: begin
        if (bus.run) begin
          state_nx   = BUFFER;
          accept_run = 1'b1;
        end
      end
      BUFFER: begin
        if (buf_cnt == 8'(BUF_CYCLES - 1)) state_nx = LAYER0;
      end
      LAYER0, LAYER1, LAYER2, LAYER3, AFFINE, ELU, COMP: begin
        if (qual_valid) state_nx = state_t'(4'(state) + 4'd1);
`ifdef NETWORK_SEQ_TIMEOUT_EN
        else if (wd_hit) begin
          state_nx  = LIDLE;
          wd_expire = 1'b1;
        end
`endif
      end
      LFIN: begin
        if (bus.out_ack) begin
          frame_done = 1'b1;
          if (bus.run) begin
            state_nx   = BUFFER;
            accept_run = 1'b1;
          end else begin
            state_nx = LIDLE;
          end
        end
      end
      default: state_nx = LIDLE;
    endcase
    if (bus.abort) begin
      state_nx   = LIDLE;
      accept_run = 1'b0;
      frame_done = 1'b0;
`ifdef NETWORK_SEQ_TIMEOUT_EN
      wd_expire  = 1'b0;
`endif
    end
  end

  // Cycles spent in BUFFER so far
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  buf_cnt <= '0;
    else if (state == BUFFER) buf_cnt <= buf_cnt + 8'd1;
    else                      buf_cnt <= '0;
  end

  // Registered decode of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_start_q <= 1'b0;
      stage_load_q  <= 1'b0;
      buf_load_q    <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      stage_start_q <= stage_start_nx;
      stage_load_q  <= is_compute(state_nx);
      buf_load_q    <= (state_nx == BUFFER);
      valid_q       <= (state_nx == LFIN);
      busy_q        <= (state_nx != LIDLE);
    end
  end

  // Completed-frame counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt_q <= '0;
    else if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  // Frame cycle counter, saturating, frozen outside BUFFER..COMP
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     cycle_cnt_q <= '0;
    else if (accept_run)                         cycle_cnt_q <= '0;
    else if (counting && (cycle_cnt_q != '1))    cycle_cnt_q <= cycle_cnt_q + CYC_W'(1);
  end

  assign bus.cs          = 4'(state);
  assign bus.stage_start = stage_start_q;
  assign bus.stage_load  = stage_load_q;
  assign bus.buf_load    = buf_load_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.cycle_cnt   = cycle_cnt_q;

endmodule

// File: doc/network_sequencer.md
# network_sequencer

Top-level schedule controller for the cube-classification network. It replaces the bare state register with a handshaked sequencer that walks the shared datapath through input buffering, four convolution passes, the affine pass, ELU and comparison, then holds the result for the consumer. It sits between the external `run`/`out_ack` handshake and the stage instances, driving `cs` (the layer-select code), per-stage load/start, and status/performance outputs.

## Interface
Parameters:
- `BUF_CYCLES`, default 1: cycles spent in BUFFER (1..255).
- `TIMEOUT`, default 4096: per-stage watchdog limit in cycles (≥2).
- `CYC_W`, default 24: width of the frame cycle counter.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `run`  in  1  — start request; sampled only in LIDLE, or in LFIN together with `out_ack`.
- `abort`  in  1  — synchronous soft abort; highest priority after `rst`.
- `stage_valid`  in  1  — done flag of the stage selected by `cs`.
- `out_ack`  in  1  — consumer has taken the result.
- `cs`  out  4  — current state code.
- `stage_load`  out  1  — high in every compute state (LAYER0..COMP).
- `stage_start`  out  1  — one-cycle pulse on the first cycle of each compute state.
- `buf_load`  out  1  — high while `cs`==BUFFER.
- `valid`  out  1  — high while `cs`==LFIN.
- `busy`  out  1  — high when `cs`≠LIDLE.
- `err`  out  1  — sticky watchdog error.
- `frame_cnt`  out  16  — completed frames.
- `cycle_cnt`  out  CYC_W  — cycles of the current or last frame.

## Operation
- State codes: LIDLE=0, BUFFER=1, LAYER0=2, LAYER1=3, LAYER2=4, LAYER3=5, AFFINE=6, ELU=7, COMP=8, LFIN=9. Codes 10–15 are illegal and go to LIDLE on the next cycle.
- Order: LIDLE → BUFFER → LAYER0 → LAYER1 → LAYER2 → LAYER3 → AFFINE → ELU → COMP → LFIN → LIDLE.
- LIDLE: `run`=1 → BUFFER. Accepting `run` clears `err` and `cycle_cnt`.
- BUFFER: stay exactly `BUF_CYCLES` cycles, then enter LAYER0.
- Compute states: `stage_valid` is ignored on the entry cycle, where `stage_start`=1. This masks a stale valid left over from the previous pass. On any later cycle, `stage_valid`=1 advances to the next state on the following edge.
- LFIN: hold until `out_ack`=1. Then:
  - `frame_cnt` increments, wrapping 0xFFFF→0.
  - If `run`=1 in the same cycle, go directly to BUFFER (clear `cycle_cnt`, clear `err`).
  - Otherwise go to LIDLE.
- `abort`=1 in any state → LIDLE next cycle. `frame_cnt` and `err` are unchanged; no result is produced.
- `cycle_cnt`:
  - Increments every cycle from BUFFER through COMP.
  - Saturates at all-ones.
  - Frozen in LFIN and LIDLE.

## Timing
- Reset values:
  - `cs`=LIDLE.
  - `stage_load`, `stage_start`, `buf_load`, `valid`, `busy`, `err` = 0.
  - `frame_cnt`=0, `cycle_cnt`=0.
- All outputs are registered or decoded from the registered `cs`. There is no combinational path from inputs to outputs.
- Latency:
  - `run` high at edge N → `cs`=BUFFER at N+1.
  - Minimum compute state length is 2 cycles.
  - Minimum frame (run to `valid`) = 1 + `BUF_CYCLES` + 7×2 cycles.
- `stage_valid` high at edge M (not the entry cycle) → next `cs` at M+1, with `stage_start`=1 on that cycle.
- `rst` asserted mid-frame: all outputs return to reset values immediately, including `frame_cnt`.
- Simultaneous events:
  - `abort` beats `stage_valid`, `out_ack` and `run`.
  - A watchdog expiry and `stage_valid` in the same cycle: `stage_valid` wins, no error.

## Configuration
- `NETWORK_SEQ_TIMEOUT_EN` defined:
  - A per-state counter resets on entry to each compute state.
  - If it reaches `TIMEOUT` without a qualified `stage_valid`, set `err`=1 and go to LIDLE next cycle.
  - `frame_cnt` is not incremented.
- Not defined:
  - No counter is synthesized and `err` is tied to 0.
  - Compute states wait indefinitely for `stage_valid`.

## Test plan
- Reset, then `run` pulse; each stage returns `stage_valid` 3 cycles after `stage_start`, `BUF_CYCLES`=1 → `cs` walks codes 0,1,2…9. There are 7 `stage_start` pulses. `valid` rises at cycle 1+1+7×4=30 after `run`; `cycle_cnt`=29 in LFIN.
- `stage_valid` held high continuously → every compute state lasts exactly 2 cycles. `valid` rises 16 cycles after `run`.
- In LFIN, assert `out_ack` and `run` together → `frame_cnt`=1 and `cs`=BUFFER next cycle, skipping LIDLE. `cycle_cnt` restarts from 0.
- `abort` during LAYER2 → `cs`=0 next cycle; `frame_cnt` unchanged; `busy`=0.
- With `NETWORK_SEQ_TIMEOUT_EN` and `TIMEOUT`=16, hold `stage_valid`=0 in AFFINE → `err`=1 and `cs`=0 after 16 cycles. The next `run` clears `err`.
- Assert `rst` while in ELU → all outputs immediately at reset values, `frame_cnt`=0.
